// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared constants and state encoding for the MAR/MDDR memory access path
package mem_ctrl_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/lat_counter.sv
// rtl/lat_counter.sv - loadable down-counter timing the memory strobe window
module lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    // Saturates at zero so a stray enable can never wrap into a long wait.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-word load/store sequencer between control unit and data memory
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam bit               LAT_OK   = (MEM_LAT >= 1) && (MEM_LAT < (1 << CNT_W));
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

    state_t            state_q;
    logic              op_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_re_q;
    logic              mem_we_q;
    logic              done_q;

    logic cnt_load;
    logic cnt_en;
    logic cnt_zero;

    assign cnt_load = (state_q == SETUP);
    assign cnt_en   = (state_q == ACCESS);

    lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .load_val_i (LOAD_VAL),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_LOAD;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        mem_addr_q <= req_addr;
                        op_q       <= req_write;
                        if (req_write == OP_STORE) begin
                            mem_wdata_q <= req_wdata;
                        end
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    // Strobes rise together with the ACCESS state so they stay registered.
                    mem_re_q <= (op_q == OP_LOAD);
                    mem_we_q <= (op_q == OP_STORE);
                    state_q  <= ACCESS;
                end
                ACCESS: begin
                    if (cnt_zero) begin
                        if (op_q == OP_LOAD) begin
                            rdata_q <= mem_rdata;
                        end
                        mem_re_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = ~req_ready;
    assign done      = done_q;
    assign rdata_out = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            a_lat_legal: assert (LAT_OK)
                else $error("mem_access_ctrl: MEM_LAT %0d illegal for CNT_W %0d", MEM_LAT, CNT_W);
            a_strobe_excl: assert (!(mem_re_q && mem_we_q));
            a_strobe_window: assert ((!mem_re_q && !mem_we_q) || (state_q == ACCESS));
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, busy, done, mem_re, mem_we;
    logic [15:0] rdata_out, mem_addr, mem_wdata, mem_rdata;

    logic        l1_req_valid, l1_req_write;
    logic [15:0] l1_req_addr, l1_req_wdata;
    logic        l1_req_ready, l1_busy, l1_done, l1_mem_re, l1_mem_we;
    logic [15:0] l1_rdata_out, l1_mem_addr, l1_mem_wdata;
    logic [15:0] l1_mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(LAT), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .busy(busy),
        .done(done), .rdata_out(rdata_out), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(1), .CNT_W(4)) dut_l1 (
        .clock(clock), .reset(reset), .req_valid(l1_req_valid), .req_write(l1_req_write),
        .req_addr(l1_req_addr), .req_wdata(l1_req_wdata), .req_ready(l1_req_ready), .busy(l1_busy),
        .done(l1_done), .rdata_out(l1_rdata_out), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_re(l1_mem_re), .mem_we(l1_mem_we), .mem_rdata(l1_mem_rdata)
    );

    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0040) return 16'hBEEF;
        return a ^ 16'h5A3C;
    endfunction

    // Memory emulator: responds to the DUT strobes like a real RAM would.
    bit [15:0] sim_mem [0:65535];
    bit        sim_wr  [0:65535];
    always @(posedge clock) begin
        if (mem_we) begin
            sim_mem[mem_addr] <= mem_wdata;
            sim_wr[mem_addr]  <= 1'b1;
        end
    end
    assign mem_rdata    = sim_wr[mem_addr] ? sim_mem[mem_addr] : init_val(mem_addr);
    assign l1_mem_rdata = 16'h0001;

    // Reference model: what memory should hold and what the controller should expose.
    logic [15:0] ref_mem [int];
    logic [15:0] exp_rdata;
    logic [15:0] exp_wdata;
    time         last_acc;

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Status vector {ready, busy, done, re, we} expected in cycle k after the accept edge.
    function automatic logic [4:0] exp_status(input int k, input int lat, input bit w);
        if (k == 1) return 5'b01000;
        if (k <= lat + 1) return {3'b010, ~w, w};
        if (k == lat + 2) return 5'b01100;
        return 5'b10000;
    endfunction

    // Called mid IDLE cycle; returns mid IDLE cycle after the transaction.
    task automatic txn(input bit w, input logic [15:0] a, input logic [15:0] d,
                       input bit noise, input bit chain, input logic [15:0] ca);
        logic [15:0] old_rd, new_rd;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(posedge clock);
        last_acc = $time;
        #1;
        if (chain) begin
            req_write = 1'b0; req_addr = ca; req_wdata = 16'($urandom);
        end else begin
            req_valid = 1'b0; req_write = 1'($urandom);
            req_addr = 16'($urandom); req_wdata = 16'($urandom);
        end
        if (w) exp_wdata = d;
        old_rd = exp_rdata;
        new_rd = w ? old_rd : ref_read(a);
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge clock);
            chk($sformatf("status_a%h_k%0d", a, k), 32'({req_ready, busy, done, mem_re, mem_we}),
                32'(exp_status(k, LAT, w)));
            if (k <= LAT + 2) begin
                chk($sformatf("mem_addr_k%0d", k), 32'(mem_addr), 32'(a));
                chk($sformatf("mem_wdata_k%0d", k), 32'(mem_wdata), 32'(exp_wdata));
            end
            chk($sformatf("rdata_a%h_k%0d", a, k), 32'(rdata_out),
                32'((k >= LAT + 2) ? new_rd : old_rd));
            if (noise && k == 2) begin
                req_valid = 1'b1; req_write = 1'($urandom);
                req_addr = 16'h0001; req_wdata = 16'($urandom);
            end
            if (noise && k == LAT + 2) req_valid = 1'b0;
        end
        if (w) ref_mem[int'(a)] = d;
        exp_rdata = new_rd;
    endtask

    logic [15:0] pool [6];
    time t1;

    initial begin
        pool = '{16'h0000, 16'h0001, 16'h0040, 16'h00FF, 16'h1234, 16'hFFFF};
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        l1_req_valid = 1'b0; l1_req_write = 1'b0; l1_req_addr = '0; l1_req_wdata = '0;
        exp_rdata = '0; exp_wdata = '0; last_acc = 0;
        repeat (2) @(negedge clock);
        chk("reset_status", 32'({req_ready, busy, done, mem_re, mem_we}), 32'(5'b10000));
        chk("reset_addr", 32'(mem_addr), 32'd0);
        chk("reset_wdata", 32'(mem_wdata), 32'd0);
        chk("reset_rdata", 32'(rdata_out), 32'd0);
        chk("reset_l1_status", 32'({l1_req_ready, l1_busy, l1_done, l1_mem_re, l1_mem_we}), 32'(5'b10000));
        reset = 1'b0;
        @(negedge clock);

        txn(1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0);
        chk("load_beef", 32'(rdata_out), 32'h0000BEEF);
        txn(1'b1, 16'h00FF, 16'h1234, 1'b0, 1'b0, 16'h0);
        chk("store_keeps_rdata", 32'(rdata_out), 32'h0000BEEF);

        txn(1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, 16'h0);
        @(negedge clock);
        chk("busy_ignore_idle", 32'({req_ready, busy, done}), 32'(3'b100));
        chk("busy_ignore_addr", 32'(mem_addr), 32'h00000040);

        txn(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'h0011);
        t1 = last_acc;
        txn(1'b0, 16'h0011, 16'h0000, 1'b0, 1'b0, 16'h0);
        chk("b2b_spacing", 32'((last_acc - t1) / 10), 32'(LAT + 3));

        // Reset during the first ACCESS cycle of a store.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h00AA; req_wdata = 16'h5555;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(posedge clock);
        #2;
        chk("rst_pre_we", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_status", 32'({req_ready, busy, done, mem_re, mem_we}), 32'(5'b10000));
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_rdata", 32'(rdata_out), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_rdata = '0;
        exp_wdata = '0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_idle_%0d", k), 32'({req_ready, busy, done, mem_re, mem_we}), 32'(5'b10000));
            @(negedge clock);
        end
        txn(1'b0, 16'h00AA, 16'h0000, 1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 40; i++) begin
            txn(1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)], 16'($urandom),
                1'($urandom_range(0, 1)), 1'b0, 16'h0);
        end

        txn(1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0);
        txn(1'b1, 16'h0000, 16'hA5A5, 1'b0, 1'b0, 16'h0);
        txn(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0);
        chk("load_after_store_0000", 32'(rdata_out), 32'h0000A5A5);

        // MEM_LAT = 1 instance: load of 16'hFFFF returning 16'h0001.
        l1_req_valid = 1'b1; l1_req_write = 1'b0; l1_req_addr = 16'hFFFF; l1_req_wdata = 16'h7777;
        @(posedge clock);
        #1 l1_req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            chk($sformatf("l1_status_k%0d", k),
                32'({l1_req_ready, l1_busy, l1_done, l1_mem_re, l1_mem_we}),
                32'(exp_status(k, 1, 1'b0)));
            if (k <= 3) chk($sformatf("l1_addr_k%0d", k), 32'(l1_mem_addr), 32'h0000FFFF);
            chk($sformatf("l1_rdata_k%0d", k), 32'(l1_rdata_out), (k >= 3) ? 32'h00000001 : 32'h0);
            chk($sformatf("l1_wdata_k%0d", k), 32'(l1_mem_wdata), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
